// File: rtl/i_type_exec_core_pkg.sv
// Shared definitions for the I-type executor: MIPS opcodes, internal ALU
// operation codes and the FSM state type.
package i_type_exec_core_pkg;

  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_e;

endpackage

// File: rtl/i_type_exec_core_if.sv
// Instruction handshake and retirement status bundle between an instruction
// source (master) and the executor core (slave).
interface i_type_exec_core_if #(
  parameter int N    = 32,
  parameter int RA_W = 5
);
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr;
  logic            done;
  logic [N-1:0]    result;
  logic [RA_W-1:0] wb_reg;
  logic            wb_en;
  logic            ovf_trap;
  logic            illegal;

  modport master (
    output instr_valid, instr,
    input  instr_ready, done, result, wb_reg, wb_en, ovf_trap, illegal
  );

  modport slave (
    input  instr_valid, instr,
    output instr_ready, done, result, wb_reg, wb_en, ovf_trap, illegal
  );
endinterface

// File: rtl/i_type_exec_core_regfile.sv
// Register file: one asynchronous read port, one synchronous write port,
// register 0 reads as zero and is never written.
module ity_regfile #(
  parameter int N    = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic [RA_W-1:0] waddr_i,
  input  logic [N-1:0]    wdata_i,
  input  logic [RA_W-1:0] raddr_i,
  output logic [N-1:0]    rdata_o
);

  logic [N-1:0] regs_q [2**RA_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**RA_W; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = (raddr_i == '0) ? '0 : regs_q[raddr_i];

endmodule

// File: rtl/i_type_exec_core.sv
// Multi-cycle MIPS I-type ALU executor: IDLE latches an instruction, EXEC reads
// rs and computes, WB writes rt and raises a one-cycle done with status flags.
module i_type_exec_core
  import i_type_exec_core_pkg::*;
#(
  parameter int N    = 32,
  parameter int RA_W = 5
) (
  input logic clk,
  input logic rst,
  i_type_exec_core_if.slave bus
);

  state_e        state_q, state_d;
  logic [31:0]   instr_q, instr_d;
  logic [N-1:0]  result_q, result_d;
  logic          ovf_q, ovf_d;
  logic          ill_q, ill_d;
  logic          wen_q, wen_d;
  logic          done_q, done_d;

  logic [5:0]      op;
  logic [RA_W-1:0] rs_addr, rt_addr;
  logic [15:0]     imm;
  logic [N-1:0]    rs_val, imm_sext, imm_zext, lui_val;
  logic [N-1:0]    opa, opb, alu_res, sum;
  logic [3:0]      alu_op;
  logic            is_ill, chk_ovf, ovf;

  assign op      = instr_q[31:26];
  assign rs_addr = instr_q[21 +: RA_W];
  assign rt_addr = instr_q[16 +: RA_W];
  assign imm     = instr_q[15:0];

  ity_regfile #(.N(N), .RA_W(RA_W)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we_i    ((state_q == S_WB) && wen_q),
    .waddr_i (rt_addr),
    .wdata_i (result_q),
    .raddr_i (rs_addr),
    .rdata_o (rs_val)
  );

  // Bitwise extension keeps N == 16 legal, where lui shifts everything out.
  always_comb begin
    imm_sext = '0;
    imm_zext = '0;
    lui_val  = '0;
    for (int i = 0; i < N; i++) begin
      if (i < 16) begin
        imm_sext[i] = imm[i[3:0]];
        imm_zext[i] = imm[i[3:0]];
      end else begin
        imm_sext[i] = imm[15];
      end
      if ((i >= 16) && (i < 32)) begin
        lui_val[i] = imm[i[3:0]];
      end
    end
  end

  always_comb begin
    alu_op  = ALU_AND;
    opa     = rs_val;
    opb     = imm_sext;
    is_ill  = 1'b0;
    chk_ovf = 1'b0;
    case (op)
      OP_ADDI:  begin alu_op = ALU_ADD; chk_ovf = 1'b1; end
      OP_ADDIU: alu_op = ALU_ADD;
      OP_SLTI:  alu_op = ALU_SLT;
      OP_ANDI:  begin alu_op = ALU_AND; opb = imm_zext; end
      OP_ORI:   begin alu_op = ALU_OR;  opb = imm_zext; end
      OP_LUI:   begin alu_op = ALU_OR;  opa = '0; opb = lui_val; end
      default:  is_ill = 1'b1;
    endcase
  end

  assign sum = opa + opb;
  assign ovf = chk_ovf && (opa[N-1] == opb[N-1]) && (sum[N-1] != opa[N-1]);

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_AND: alu_res = opa & opb;
      ALU_OR:  alu_res = opa | opb;
      ALU_ADD: alu_res = sum;
      ALU_SLT: alu_res[0] = ($signed(opa) < $signed(opb));
      default: alu_res = '0;
    endcase
    if (is_ill) begin
      alu_res = '0;
    end
  end

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    ill_d    = ill_q;
    wen_d    = wen_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.instr_valid) begin
          instr_d = bus.instr;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        result_d = alu_res;
        ovf_d    = ovf;
        ill_d    = is_ill;
        wen_d    = !is_ill && !ovf && (rt_addr != '0);
        state_d  = S_WB;
      end
      S_WB: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      instr_q  <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
      wen_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
      wen_q    <= wen_d;
      done_q   <= done_d;
    end
  end

  // Status flags persist between instructions, so they are qualified by done.
  assign bus.instr_ready = (state_q == S_IDLE);
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.wb_reg      = rt_addr;
  assign bus.wb_en       = done_q & wen_q;
  assign bus.ovf_trap    = done_q & ovf_q;
  assign bus.illegal     = done_q & ill_q;

endmodule

// File: tb/tb_i_type_exec_core.sv
// Scoreboard bench for i_type_exec_core: a reference register-file model
// predicts each retirement, the monitor compares every done pulse.
module tb_i_type_exec_core;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        wen;
    logic        ovf;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic prevDone = 1'b0;

  exp_t        sbq[$];
  logic [31:0] model [32];
  int          acceptCyc[$];

  i_type_exec_core_if #(.N(32), .RA_W(5)) bus ();

  i_type_exec_core #(.N(32), .RA_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input int rs, input int rt,
                                     input logic [15:0] imm);
    logic [4:0] rsf, rtf;
    rsf = rs[4:0];
    rtf = rt[4:0];
    return {op, rsf, rtf, imm};
  endfunction

  // Reference behaviour taken from the opcode table; updates the model registers.
  function automatic exp_t predict(input logic [31:0] w);
    exp_t        e;
    logic [5:0]  op;
    logic [15:0] imm;
    logic [31:0] a, sx, zx;
    op    = w[31:26];
    imm   = w[15:0];
    a     = model[w[25:21]];
    sx    = {{16{imm[15]}}, imm};
    zx    = {16'h0000, imm};
    e.rd  = w[20:16];
    e.ovf = 1'b0;
    e.ill = 1'b0;
    case (op)
      6'b001000: begin
        e.res = a + sx;
        e.ovf = (a[31] == sx[31]) && (e.res[31] != a[31]);
      end
      6'b001001: e.res = a + sx;
      6'b001010: e.res = ($signed(a) < $signed(sx)) ? 32'd1 : 32'd0;
      6'b001100: e.res = a & zx;
      6'b001101: e.res = a | zx;
      6'b001111: e.res = {imm, 16'h0000};
      default: begin
        e.res = 32'd0;
        e.ill = 1'b1;
      end
    endcase
    e.wen = !e.ill && !e.ovf && (e.rd != 5'd0);
    if (e.wen) model[e.rd] = e.res;
    return e;
  endfunction

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic applyStimulus(input logic [31:0] w);
    int n;
    n = 0;
    bus.instr_valid = 1'b1;
    bus.instr       = w;
    while (!bus.instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checkOutput("accept_timeout", 32'(n), 32'd0);
    end else begin
      sbq.push_back(predict(w));
      acceptCyc.push_back(cyc + 1);
    end
    @(negedge clk);
    bus.instr_valid = 1'b0;
    bus.instr       = $urandom;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", 32'(sbq.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.done) begin
      exp_t e;
      checkOutput("done_width", {31'd0, prevDone}, 32'd0);
      checkOutput("ready_with_done", {31'd0, bus.instr_ready}, 32'd1);
      if (sbq.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        checkOutput("result", bus.result, e.res);
        checkOutput("wb_reg", {27'd0, bus.wb_reg}, {27'd0, e.rd});
        checkOutput("wb_en", {31'd0, bus.wb_en}, {31'd0, e.wen});
        checkOutput("ovf_trap", {31'd0, bus.ovf_trap}, {31'd0, e.ovf});
        checkOutput("illegal", {31'd0, bus.illegal}, {31'd0, e.ill});
      end
    end
    prevDone <= bus.done;
  end

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    bus.instr_valid = 1'b0;
    bus.instr       = 32'd0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", {31'd0, bus.instr_ready}, 32'd1);
    checkOutput("rst_done", {31'd0, bus.done}, 32'd0);
    checkOutput("rst_result", bus.result, 32'd0);
    checkOutput("rst_wb_en", {31'd0, bus.wb_en}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] T1 ori after reset");
    applyStimulus(mk(6'b001101, 0, 1, 16'h0000));
    waitDrain();

    $display("[TB] T2 back-to-back addi");
    acceptCyc.delete();
    applyStimulus(mk(6'b001000, 0, 16, 16'd20));
    applyStimulus(mk(6'b001000, 16, 17, 16'hFFFF));
    checkOutput("accept_spacing", 32'(acceptCyc[1] - acceptCyc[0]), 32'd3);
    waitDrain();

    $display("[TB] T3 overflow and wrap");
    applyStimulus(mk(6'b001111, 0, 2, 16'h7FFF));
    applyStimulus(mk(6'b001101, 2, 2, 16'hFFFF));
    applyStimulus(mk(6'b001000, 2, 3, 16'h0001));
    applyStimulus(mk(6'b001101, 3, 4, 16'h0000));
    applyStimulus(mk(6'b001001, 2, 3, 16'h0001));

    $display("[TB] T4 slti and zero-extended logic ops");
    applyStimulus(mk(6'b001010, 3, 5, 16'h0000));
    applyStimulus(mk(6'b001100, 2, 6, 16'hFFFF));
    applyStimulus(mk(6'b001010, 2, 11, 16'h0005));
    applyStimulus(mk(6'b001101, 0, 12, 16'h8000));
    applyStimulus(mk(6'b001000, 0, 13, 16'h8000));
    applyStimulus(mk(6'b001000, 13, 13, 16'h0010));

    $display("[TB] T5 illegal opcode and R0 writes");
    applyStimulus(mk(6'b101011, 2, 2, 16'h1234));
    applyStimulus(mk(6'b001101, 2, 10, 16'h0000));
    applyStimulus(mk(6'b001000, 0, 0, 16'h0005));
    applyStimulus(mk(6'b001101, 0, 14, 16'h0000));

    $display("[TB] instr ignored while busy");
    applyStimulus(mk(6'b001101, 0, 15, 16'h0055));
    bus.instr_valid = 1'b1;
    bus.instr       = mk(6'b001000, 0, 9, 16'd77);
    @(negedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    applyStimulus(mk(6'b001101, 9, 18, 16'h0000));
    waitDrain();

    $display("[TB] T6 reset mid-EXEC");
    bus.instr_valid = 1'b1;
    bus.instr       = mk(6'b001000, 0, 7, 16'd9);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("rst_async_ready", {31'd0, bus.instr_ready}, 32'd1);
    checkOutput("rst_async_done", {31'd0, bus.done}, 32'd0);
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    applyStimulus(mk(6'b001101, 7, 8, 16'h0000));
    applyStimulus(mk(6'b001101, 2, 19, 16'h0000));
    waitDrain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
